// File: rtl/ix_muldiv_unit.sv
// ix_muldiv_unit: iterative multiply/divide unit for the IX stage.
// Owns the architectural HI/LO registers, runs MULT/MULTU/DIV/DIVU as
// multi-cycle radix-2 operations, serves MFHI/MFLO/MTHI/MTLO and raises
// a stall while a HI/LO hazard is outstanding.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply early termination
// and single-cycle divide-by-zero). Default build has fixed latency.
module ix_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [5:0]      alu_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_LAST  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   X_ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   X_ONES    = {XLEN{1'b1}};
    localparam logic [2*XLEN-1:0] X2_ZERO   = {(2*XLEN){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of a possibly-signed operand (two's-complement negate when
    // the operand is treated as signed and its sign bit is set).
    function automatic logic [XLEN-1:0] mag_f(input logic [XLEN-1:0] v,
                                              input logic            is_signed);
        if (is_signed && v[XLEN-1]) begin
            mag_f = -v;
        end else begin
            mag_f = v;
        end
    endfunction

    // Conditional two's-complement negate of an XLEN-bit value.
    function automatic logic [XLEN-1:0] cneg_f(input logic [XLEN-1:0] v,
                                               input logic            neg);
        if (neg) begin
            cneg_f = -v;
        end else begin
            cneg_f = v;
        end
    endfunction

    // Architectural and iteration state
    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [2*XLEN-1:0] acc_r;      // mul: running product; div: {remainder, dividend/quotient}
    logic [2*XLEN-1:0] mcand_r;    // mul: multiplicand, shifted left each step
    logic [XLEN-1:0]   opb_r;      // mul: multiplier (shifts right); div: divisor
    logic [XLEN-1:0]   a_orig_r;   // original dividend, returned on divide by zero
    logic              is_div_r;
    logic              div0_r;
    logic              neg_pq_r;   // negate product (mul) or quotient (div)
    logic              neg_rem_r;  // negate remainder
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic              done_r;

    // Decode and datapath signals
    logic              is_mul_s;
    logic              is_div_op_s;
    logic              is_signed_s;
    logic              is_mfhi_s;
    logic              is_mflo_s;
    logic              is_mthi_s;
    logic              is_mtlo_s;
    logic              is_muldiv_s;
    logic              is_hilo_s;
    logic              busy_s;
    logic              start_s;
    logic              mt_hi_s;
    logic              mt_lo_s;
    logic              b_zero_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [2*XLEN-1:0] mul_sum_s;
    logic [2*XLEN:0]   div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic [2*XLEN-1:0] div_next_s;
    logic              mul_rest_zero_s;
    logic              calc_last_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_hi_s;
    logic [XLEN-1:0]   fix_lo_s;

    // Decode the funct code into operation classes
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_op_s = 1'b0;
        is_signed_s = 1'b0;
        is_mfhi_s   = 1'b0;
        is_mflo_s   = 1'b0;
        is_mthi_s   = 1'b0;
        is_mtlo_s   = 1'b0;
        case (alu_op)
            OP_MULT:  begin is_mul_s    = 1'b1; is_signed_s = 1'b1; end
            OP_MULTU: begin is_mul_s    = 1'b1;                     end
            OP_DIV:   begin is_div_op_s = 1'b1; is_signed_s = 1'b1; end
            OP_DIVU:  begin is_div_op_s = 1'b1;                     end
            OP_MFHI:  begin is_mfhi_s   = 1'b1;                     end
            OP_MFLO:  begin is_mflo_s   = 1'b1;                     end
            OP_MTHI:  begin is_mthi_s   = 1'b1;                     end
            OP_MTLO:  begin is_mtlo_s   = 1'b1;                     end
            default:  begin                                         end
        endcase
    end

    // Issue control: acceptance, HI/LO moves and hazard stall
    always_comb begin
        busy_s       = (state_r != ST_IDLE);
        is_muldiv_s  = is_mul_s | is_div_op_s;
        is_hilo_s    = is_mfhi_s | is_mflo_s | is_mthi_s | is_mtlo_s;
        start_s      = req_valid & is_muldiv_s & ~busy_s;
        mt_hi_s      = req_valid & is_mthi_s & ~busy_s;
        mt_lo_s      = req_valid & is_mtlo_s & ~busy_s;
        stall        = req_valid & busy_s & (is_muldiv_s | is_hilo_s);
        result_valid = req_valid & (is_mfhi_s | is_mflo_s) & ~stall;
        b_zero_s     = (B == X_ZERO);
        mag_a_s      = mag_f(A, is_signed_s);
        mag_b_s      = mag_f(B, is_signed_s);
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        if (opb_r[0]) begin
            mul_sum_s = acc_r + mcand_r;
        end else begin
            mul_sum_s = acc_r;
        end
        div_shift_s = {acc_r, 1'b0};
        div_diff_s  = div_shift_s[2*XLEN:XLEN] - {1'b0, opb_r};
        if (div_diff_s[XLEN]) begin
            div_next_s = div_shift_s[2*XLEN-1:0];
        end else begin
            div_next_s = {div_diff_s[XLEN-1:0], div_shift_s[XLEN-1:1], 1'b1};
        end
`ifdef MULDIV_EARLY_OUT_EN
        mul_rest_zero_s = ~is_div_r & (opb_r[XLEN-1:1] == {(XLEN-1){1'b0}});
`else
        mul_rest_zero_s = 1'b0;
`endif
        calc_last_s = (cnt_r == CNT_LAST) | mul_rest_zero_s;
    end

    // Sign correction and final HI/LO values written in FIX
    always_comb begin
        if (neg_pq_r) begin
            prod_s = -acc_r;
        end else begin
            prod_s = acc_r;
        end
        if (div0_r) begin
            fix_hi_s = a_orig_r;
            fix_lo_s = X_ONES;
        end else if (is_div_r) begin
            fix_hi_s = cneg_f(acc_r[2*XLEN-1:XLEN], neg_rem_r);
            fix_lo_s = cneg_f(acc_r[XLEN-1:0], neg_pq_r);
        end else begin
            fix_hi_s = prod_s[2*XLEN-1:XLEN];
            fix_lo_s = prod_s[XLEN-1:0];
        end
    end

    // Main FSM: accept, iterate, sign-fix and commit HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            acc_r     <= X2_ZERO;
            mcand_r   <= X2_ZERO;
            opb_r     <= X_ZERO;
            a_orig_r  <= X_ZERO;
            is_div_r  <= 1'b0;
            div0_r    <= 1'b0;
            neg_pq_r  <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= X_ZERO;
            lo_r      <= X_ZERO;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_s) begin
                        is_div_r  <= is_div_op_s;
                        div0_r    <= is_div_op_s & b_zero_s;
                        neg_pq_r  <= is_signed_s & (A[XLEN-1] ^ B[XLEN-1]);
                        neg_rem_r <= is_signed_s & A[XLEN-1];
                        a_orig_r  <= A;
                        opb_r     <= mag_b_s;
                        mcand_r   <= {X_ZERO, mag_a_s};
                        acc_r     <= is_div_op_s ? {X_ZERO, mag_a_s} : X2_ZERO;
                        cnt_r     <= CNT_ZERO;
`ifdef MULDIV_EARLY_OUT_EN
                        state_r   <= (is_div_op_s & b_zero_s) ? ST_FIX : ST_CALC;
`else
                        state_r   <= ST_CALC;
`endif
                    end else begin
                        if (mt_hi_s) begin
                            hi_r <= A;
                        end
                        if (mt_lo_s) begin
                            lo_r <= A;
                        end
                    end
                end
                ST_CALC: begin
                    done_r <= 1'b0;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (is_div_r) begin
                        acc_r <= div_next_s;
                    end else begin
                        acc_r   <= mul_sum_s;
                        mcand_r <= {mcand_r[2*XLEN-2:0], 1'b0};
                        opb_r   <= {1'b0, opb_r[XLEN-1:1]};
                    end
                    if (calc_last_s) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output mapping: MFHI/MFLO read data and register views
    always_comb begin
        if (is_mfhi_s) begin
            result = hi_r;
        end else if (is_mflo_s) begin
            result = lo_r;
        end else begin
            result = X_ZERO;
        end
        busy = busy_s;
        done = done_r;
        hi   = hi_r;
        lo   = lo_r;
    end

endmodule

// File: tb/tb_ix_muldiv_unit.sv
// Self-checking bench for ix_muldiv_unit: directed scenarios plus random
// mul/div operations checked against a plain-arithmetic reference model.
module tb_ix_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
    localparam logic [5:0] OP_ADD   = 6'h20;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic [5:0]      alu_op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    ix_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .alu_op       (alu_op),
        .A            (A),
        .B            (B),
        .result       (result),
        .result_valid (result_valid),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        bit ok;
        ok = (obs === exp);
        total_cnt++;
        assert (ok) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference results from plain arithmetic on the instruction semantics
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = 32'h0;
        el = 32'h0;
        if (op == OP_MULT) begin
            p = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else if (op == OP_MULTU) begin
            p = {32'h0, a} * {32'h0, b};
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'h0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            el = sq[31:0];
            eh = sr[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    // Expected number of busy cycles for a mul/div
    function automatic int exp_busy(input logic [5:0] op, input logic [31:0] b);
        logic [31:0] m;
        int n;
        m = (op == OP_MULT && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        if (!EARLY) return XLEN + 1;
        if (op == OP_DIV || op == OP_DIVU) return (b == 32'h0) ? 1 : XLEN + 1;
        return n + 1;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int eb, n;
        model(op, a, b, eh, el);
        eb = exp_busy(op, b);
        req_valid = 1'b1; alu_op = op; A = a; B = b;
        #1;
        check({tag, "_issue_stall"}, {63'h0, stall}, 64'h0);
        tick();
        req_valid = 1'b0; alu_op = OP_ADD; A = $urandom; B = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(eb));
        check({tag, "_done"}, {63'h0, done}, 64'h1);
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
        tick();
        check({tag, "_done_clear"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int n, eb, add_cycles;
        logic [5:0] op;
        logic [31:0] ra, rb;

        // Reset state
        rst_n = 1'b0; req_valid = 1'b1; alu_op = OP_MULT; A = 32'h5; B = 32'h7;
        #12;
        check("rst_busy",  {63'h0, busy},  64'h0);
        check("rst_stall", {63'h0, stall}, 64'h0);
        check("rst_done",  {63'h0, done},  64'h0);
        check("rst_hi",    {32'h0, hi},    64'h0);
        check("rst_lo",    {32'h0, lo},    64'h0);
        req_valid = 1'b0; alu_op = OP_ADD;
        #2 rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFE, 32'h3);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg7",  OP_DIV,   32'hFFFF_FFF9, 32'h2);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero", OP_DIVU,  32'h0000_1234, 32'h0);
        run_op("div_zero",  OP_DIV,   32'h8765_4321, 32'h0);
        run_op("multu_5x1", OP_MULTU, 32'h5, 32'h1);
        run_op("mult_zero", OP_MULT,  32'h1234_5678, 32'h0);

        // MULT 6*7 with independent ADD traffic, then a waiting MFLO
        eb = exp_busy(OP_MULT, 32'h7);
        add_cycles = (eb > 5) ? 4 : 1;
        req_valid = 1'b1; alu_op = OP_MULT; A = 32'h6; B = 32'h7;
        tick();
        alu_op = OP_ADD; A = 32'hFFFF; B = 32'h1;
        for (int i = 0; i < add_cycles; i++) begin
            #1;
            check("add_no_stall", {63'h0, stall}, 64'h0);
            check("add_no_result", {31'h0, result_valid, result}, 64'h0);
            tick();
        end
        alu_op = OP_MFLO;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("mflo_stall_cycles", 64'(n), 64'(eb - add_cycles));
        check("mflo_done_cycle", {63'h0, done}, 64'h1);
        check("mflo_result", {32'h0, result}, 64'h2A);
        check("mflo_valid", {63'h0, result_valid}, 64'h1);
        tick();
        req_valid = 1'b0; alu_op = OP_ADD;
        tick();

        // MTHI while idle
        req_valid = 1'b1; alu_op = OP_MTHI; A = 32'hDEAD_BEEF;
        #1;
        check("mthi_stall", {63'h0, stall}, 64'h0);
        tick();
        check("mthi_hi", {32'h0, hi}, 64'hDEAD_BEEF);
        req_valid = 1'b0; alu_op = OP_ADD;

        // MTLO during DIV: stalls until done, then overwrites the quotient
        eb = exp_busy(OP_DIV, 32'h7);
        req_valid = 1'b1; alu_op = OP_DIV; A = 32'd100; B = 32'd7;
        tick();
        alu_op = OP_MTLO; A = 32'hCAFE_F00D; B = 32'h0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("mtlo_stall_cycles", 64'(n), 64'(eb));
        check("mtlo_done", {63'h0, done}, 64'h1);
        check("mtlo_quot", {32'h0, lo}, 64'd14);
        check("mtlo_rem",  {32'h0, hi}, 64'd2);
        tick();
        check("mtlo_lo", {32'h0, lo}, 64'hCAFE_F00D);
        check("mtlo_hi_kept", {32'h0, hi}, 64'd2);
        alu_op = OP_MFHI;
        #1;
        check("mfhi_result", {32'h0, result}, 64'd2);
        check("mfhi_valid", {63'h0, result_valid}, 64'h1);
        req_valid = 1'b0; alu_op = OP_ADD;
        tick();

        // Random mul/div against the reference model
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: op = OP_MULT;
                1: op = OP_MULTU;
                2: op = OP_DIV;
                default: op = OP_DIVU;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op("rand", op, ra, rb);
        end

        // Asynchronous reset in the middle of a DIV
        req_valid = 1'b1; alu_op = OP_DIV; A = 32'h7FFF_0000; B = 32'h3;
        tick();
        alu_op = OP_MFHI;
        for (int i = 0; i < 9; i++) tick();
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy",  {63'h0, busy},  64'h0);
        check("arst_stall", {63'h0, stall}, 64'h0);
        check("arst_hi",    {32'h0, hi},    64'h0);
        check("arst_lo",    {32'h0, lo},    64'h0);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_stall", {63'h0, stall}, 64'h0);
        check("post_rst_mfhi",  {32'h0, result}, 64'h0);
        check("post_rst_valid", {63'h0, result_valid}, 64'h1);
        req_valid = 1'b0; alu_op = OP_ADD;
        for (int i = 0; i < 40; i++) tick();
        check("abort_no_write_hi", {32'h0, hi}, 64'h0);
        check("abort_no_write_lo", {32'h0, lo}, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
